muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide sequencer for the RISC-V pipeline's M-extension subset (MUL, MULHU, DIVU, REMU). It computes each result without a dedicated multiplier or divider. Instead, it drives a W-bit ALU instance one ADD or SUB per cycle for DATA_WIDTH cycles, and keeps all shift, carry and quotient state locally. It sits beside the execute stage and stalls the pipeline through `busy` until `done`.

## Interface
- DATA_WIDTH, 32, operand/result width W; iteration count equals W.
- OPCODE_LENGTH, 4, width of the ALU operation code.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL (low W bits), 01 MULHU (high W bits, unsigned), 10 DIVU, 11 REMU.
- a  input  W  multiplicand / dividend; latched on accepted start.
- b  input  W  multiplier / divisor; latched on accepted start.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse in DONE; result valid.
- result  output  W  registered result; held until the next accepted start.
- alu_srca  output  W  ALU SrcA.
- alu_srcb  output  W  ALU SrcB.
- alu_op  output  OPCODE_LENGTH  ALU Operation: ADD = 4'b0100, SUB = 4'b0101.
- alu_result  input  W  ALUResult, combinational return from the same-cycle operands.

## Operation
- States:
  - IDLE: if start, latch op/a/b, init registers, cnt=0, go to CALC.
  - CALC: one iteration per cycle; when cnt==W-1, go to DONE.
  - DONE: done=1, write result, go to IDLE.
  - No other transitions.
- Registers: hi (W), lo (W), divisor/multiplicand md (W), cnt (ceil log2 W), op_q.
- MUL/MULHU init: hi=0, lo=b, md=a.
- MUL/MULHU per cycle:
  - alu_op=ADD, alu_srca=hi, alu_srcb = lo[0] ? md : 0.
  - carry = (alu_result < alu_srca), unsigned compare.
  - {hi,lo} <= {carry, alu_result, lo} >> 1, i.e. a 2W+1-bit value right-shifted one bit.
- MUL/MULHU finish: MUL result = lo; MULHU result = hi.
- DIVU/REMU init: hi=0, lo=a, md=b.
- DIVU/REMU per cycle (restoring division):
  - msb = hi[W-1]; r = {hi[W-2:0], lo[W-1]}.
  - alu_op=SUB, alu_srca=r, alu_srcb=md.
  - If msb or r >= md (unsigned): hi <= alu_result, lo <= {lo[W-2:0],1}.
  - Else: hi <= r, lo <= {lo[W-2:0],0}.
- DIVU/REMU finish: DIVU result = lo; REMU result = hi.
- Divide by zero: falls out of the algorithm with no special case and the same latency. DIVU = all ones; REMU = a.
- ALU operands outside CALC: alu_srca=0, alu_srcb=0, alu_op=ADD.
- All arithmetic is unsigned and modulo 2^W; the carry/borrow is derived locally, not taken from the ALU.

## Timing
- Cycle 0 is the edge where start is sampled in IDLE.
- CALC occupies cycles 1..W.
- DONE at cycle W+1: done=1, result valid from this cycle.
- IDLE at cycle W+2. A start may be accepted at W+2 at the earliest; throughput is one op per W+2 cycles.
- start while busy=1 is ignored and not queued. a, b and op changes after acceptance have no effect.
- busy rises the cycle after the accepted start and falls when re-entering IDLE.
- done never lasts more than one cycle.
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, result=0, hi=lo=md=0, cnt=0. ALU outputs go to idle values.
  - Reset mid-CALC aborts the operation with no done pulse.
  - The first start after reset release is accepted normally.

## Test plan
- MUL a=6, b=7 → done pulse exactly at cycle 33 (W=32) with result=42; busy high cycles 1–33; alu_op=0100 throughout CALC.
- MULHU a=b=0xFFFFFFFF → result=0xFFFFFFFE; repeat with MUL → result=0x00000001.
- DIVU a=100, b=7 → result=14; REMU a=100, b=7 → result=2; alu_op=0101 throughout CALC.
- DIVU a=0x12345678, b=0 → 0xFFFFFFFF; REMU same operands → 0x12345678; both at cycle 33.
- Back-to-back flow:
  - Start MUL 3×5; pulse start again at cycle 10 with different operands → ignored, result=15.
  - Hold start high through DONE → second op accepted at cycle 34; its done arrives at cycle 67.
- Reset asserted at cycle 12 of a DIVU → outputs reset immediately and no done pulse. A new MUL 2×2 after release → result=4 at normal latency.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative MUL/MULHU/DIVU/REMU sequencer: borrows an external W-bit ALU for one
// ADD or SUB per cycle and keeps the shift, carry and quotient state locally.
module muldiv_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD  = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB  = OPCODE_LENGTH'(4'b0101);
  localparam logic [CW-1:0]            CNT_LAST = CW'(DATA_WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] md_q, md_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  carry;
  logic                  msb;
  logic [DATA_WIDTH-1:0] rem;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    md_d     = md_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    alu_srca = '0;
    alu_srcb = '0;
    alu_op   = ALU_ADD;
    carry    = 1'b0;
    msb      = 1'b0;
    rem      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = S_CALC;
          if (op[1]) begin
            lo_d = a;
            md_d = b;
          end else begin
            lo_d = b;
            md_d = a;
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!op_q[1]) begin
          // Shift-add multiply; carry out recovered from unsigned wrap of the sum.
          alu_srca = hi_q;
          alu_srcb = lo_q[0] ? md_q : '0;
          carry    = (alu_result < alu_srca);
          hi_d     = {carry, alu_result[DATA_WIDTH-1:1]};
          lo_d     = {alu_result[0], lo_q[DATA_WIDTH-1:1]};
        end else begin
          msb      = hi_q[DATA_WIDTH-1];
          rem      = {hi_q[DATA_WIDTH-2:0], lo_q[DATA_WIDTH-1]};
          alu_op   = ALU_SUB;
          alu_srca = rem;
          alu_srcb = md_q;
          if (msb || (rem >= md_q)) begin
            hi_d = alu_result;
            lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
          end else begin
            hi_d = rem;
            lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        // Result is captured on the final iteration so it is already valid while in DONE.
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = op_q[0] ? hi_d : lo_d;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      md_q     <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      md_q     <= md_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: a small ALU stub, a cycle-count/arithmetic reference
// model, a per-cycle comparator, and directed operations with literal expectations.
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [3:0] ADD = 4'b0100;
  localparam logic [3:0] SUB = 4'b0101;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result, alu_srca, alu_srcb, alu_result;
  logic [3:0]   alu_op;

  int checks   = 0;
  int failures = 0;

  muldiv_sequencer #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
    .alu_result(alu_result)
  );

  assign alu_result = (alu_op == ADD) ? alu_srca + alu_srcb :
                      (alu_op == SUB) ? alu_srca - alu_srcb : '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'b00:   return prod[W-1:0];
      2'b01:   return prod[2*W-1:W];
      2'b10:   return (y == 0) ? '1 : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Reference: k counts cycles since acceptance (0 = idle), done when k == W+1.
  int           k = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_result = '0;
  logic [1:0]   m_op = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0;
      m_result = '0;
    end else if (k == 0) begin
      if (start) begin
        k = 1;
        m_pend = ref_result(op, a, b);
        m_op = op;
      end
    end else if (k == W + 1) begin
      k = 0;
    end else begin
      k = k + 1;
      if (k == W + 1) m_result = m_pend;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      chk("busy", busy, k != 0);
      chk("done", done, k == W + 1);
      chk("result", result, m_result);
      if (k >= 1 && k <= W) begin
        chk("alu_op_calc", alu_op, m_op[1] ? SUB : ADD);
      end else begin
        chk("alu_op_idle", alu_op, ADD);
        chk("alu_srca_idle", alu_srca, 0);
        chk("alu_srcb_idle", alu_srcb, 0);
      end
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp_lit);
    int dcyc;
    int bcnt;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    dcyc = -1;
    bcnt = 0;
    for (int j = 1; j <= 40; j++) begin
      if (j > 1) @(negedge clk);
      if (busy) bcnt++;
      if (done && dcyc < 0) dcyc = j;
    end
    chk("done_cycle", dcyc, W + 1);
    chk("busy_cycles", bcnt, W + 1);
    chk("lit_result", result, exp_lit);
  endtask

  initial begin
    int d1, d2, dcnt;
    logic [W-1:0] r1, r2;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #1 reset = 1'b1;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);
    reset = 1'b0;

    run_op(2'b00, 32'd6, 32'd7, 32'd42);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(2'b10, 32'd100, 32'd7, 32'd14);
    run_op(2'b11, 32'd100, 32'd7, 32'd2);
    run_op(2'b10, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678);
    run_op(2'b01, 32'h8000_0001, 32'd6, 32'd3);

    // Start pulse mid-operation must be dropped.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    d1 = -1;
    for (int j = 1; j <= 40; j++) begin
      if (j > 1) @(negedge clk);
      if (j == 10) begin start = 1'b1; a = 32'd9; b = 32'd9; end
      if (j == 11) start = 1'b0;
      if (done && d1 < 0) d1 = j;
    end
    chk("ignored_done_cycle", d1, 33);
    chk("ignored_result", result, 15);

    // Start held high: next op accepted right as IDLE is re-entered.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(negedge clk);
    d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    for (int j = 1; j <= 75; j++) begin
      if (j > 1) @(negedge clk);
      if (j == 20) begin op = 2'b10; a = 32'd81; b = 32'd9; end
      if (j == 35) start = 1'b0;
      if (done && d1 < 0) begin d1 = j; r1 = result; end
      else if (done && d2 < 0) begin d2 = j; r2 = result; end
    end
    chk("b2b_done1_cycle", d1, 33);
    chk("b2b_result1", r1, 15);
    chk("b2b_done2_cycle", d2, 67);
    chk("b2b_result2", r2, 9);

    // Asynchronous reset in the middle of a DIVU.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int j = 2; j <= 12; j++) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_alu_op", alu_op, ADD);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("rst_no_done", dcnt, 0);
    run_op(2'b00, 32'd2, 32'd2, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
